wb_cache_ctrl: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate cache controller with multi-word lines, a request/ready handshake to the CPU, and a request/acknowledge handshake to main memory. It sits between the core's load/store path and the memory bus and replaces the single-word, fixed-geometry controller. Over that controller it adds:

- configurable data width, line count and line size;
- burst write-back and refill that tolerate a variable number of wait states;
- saturating hit and miss counters.

---
 rtl/wb_cache_ctrl.sv | 155 +++++++++++++++
 tb/tb_wb_cache_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with multi-word lines,
// burst write-back/refill over a req/ack memory port and saturating hit/miss counters.
module wb_cache_ctrl #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES       = 1 << INDEX_W;
    localparam int WORDS_TOTAL = 1 << (INDEX_W + OFFSET_W);

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, RESPOND} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] data_arr [WORDS_TOTAL];
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;

    logic [ADDR_W-1:0]   req_addr;
    logic                req_we;
    logic [DATA_W-1:0]   req_wdata;
    logic [OFFSET_W-1:0] beat;
    logic                post_refill;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic [TAG_W-1:0]    victim_tag;
    logic                hit;
    logic                beat_done;
    logic                last_beat;

    assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx    = req_addr[OFFSET_W +: INDEX_W];
    assign req_off    = req_addr[OFFSET_W-1:0];
    assign victim_tag = tag_arr[req_idx];
    assign hit        = valid[req_idx] && (victim_tag == req_tag);
    assign beat_done  = mem_req && mem_ack;
    assign last_beat  = beat_done && (beat == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Memory-side outputs are decoded from state so that reset drops mem_req immediately.
    always_comb begin
        state_next = state;
        cpu_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (cpu_req) state_next = COMPARE;
            end
            COMPARE: begin
                if (hit)                  state_next = RESPOND;
                else if (dirty[req_idx])  state_next = WRITEBACK;
                else                      state_next = REFILL;
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {victim_tag, req_idx, beat};
                mem_wdata = data_arr[{req_idx, beat}];
                if (last_beat) state_next = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, beat};
                if (last_beat) state_next = COMPARE;
            end
            RESPOND: begin
                cpu_ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr    <= '0;
            req_we      <= 1'b0;
            req_wdata   <= '0;
            beat        <= '0;
            post_refill <= 1'b0;
            cpu_rdata   <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            valid       <= '0;
            dirty       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr    <= cpu_addr;
                        req_we      <= cpu_we;
                        req_wdata   <= cpu_wdata;
                        post_refill <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_we) dirty[req_idx] <= 1'b1;
                        else        cpu_rdata      <= data_arr[{req_idx, req_off}];
                        // The hit that completes a refilled miss is not a second event.
                        if (!post_refill && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                    end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                        beat <= '0;
                    end
                end
                WRITEBACK, REFILL: begin
                    if (beat_done) beat <= beat + 1'b1;
                end
                default: ;
            endcase
            if (state == REFILL && last_beat) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
                post_refill    <= 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_we) data_arr[{req_idx, req_off}] <= req_wdata;
        if (state == REFILL && beat_done)      data_arr[{req_idx, beat}]    <= mem_rdata;
        if (state == REFILL && last_beat)      tag_arr[req_idx]             <= req_tag;
    end
endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Directed bench for wb_cache_ctrl: behavioural memory with configurable wait states,
// a main instance and a CNT_W=2 instance driven in lockstep for counter saturation.
`timescale 1ns/1ps
module tb_wb_cache_ctrl;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req, cpu_we;
    logic [29:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt, miss_cnt;

    logic        sat_cpu_ready;
    logic [31:0] sat_cpu_rdata;
    logic        sat_mem_req, sat_mem_we;
    logic [29:0] sat_mem_addr;
    logic [31:0] sat_mem_wdata;
    logic [1:0]  sat_hit_cnt, sat_miss_cnt;

    wb_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    wb_cache_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(sat_cpu_ready), .cpu_rdata(sat_cpu_rdata),
        .mem_req(sat_mem_req), .mem_we(sat_mem_we), .mem_addr(sat_mem_addr),
        .mem_wdata(sat_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(sat_hit_cnt), .miss_cnt(sat_miss_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_model [4096];
    logic [29:0] log_addr  [$];
    logic        log_we    [$];
    logic [31:0] log_wdata [$];
    int          wait_states = 0;
    int          wait_cnt    = 0;
    int          stab_err    = 0;
    int          sat_div     = 0;
    logic        stray_ack   = 1'b0;
    logic [29:0] hold_addr;
    logic [31:0] hold_wdata;
    logic        hold_we;

    // Memory responder: decides ack at the falling edge, beat completes at the next rising edge.
    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = 32'(i) ^ 32'hA5A50000;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        hold_addr = '0; hold_wdata = '0; hold_we = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                if (wait_cnt > 0 && (mem_addr !== hold_addr || mem_we !== hold_we ||
                                     mem_wdata !== hold_wdata)) stab_err++;
                hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
                if (wait_cnt < wait_states) begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hBAD0BAD0;
                    wait_cnt++;
                end else begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    log_addr.push_back(mem_addr);
                    log_we.push_back(mem_we);
                    log_wdata.push_back(mem_wdata);
                    if (mem_we) mem_model[mem_addr[11:0]] = mem_wdata;
                    else        mem_rdata = mem_model[mem_addr[11:0]];
                end
            end else begin
                mem_ack   = stray_ack;
                mem_rdata = 32'hBAD0BAD0;
                wait_cnt  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (sat_cpu_ready !== cpu_ready || sat_cpu_rdata !== cpu_rdata ||
            sat_mem_req !== mem_req || sat_mem_we !== mem_we ||
            sat_mem_addr !== mem_addr || sat_mem_wdata !== mem_wdata) sat_div++;
    end

    task automatic access(input logic we, input logic [29:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int cycles);
        int n;
        log_addr.delete(); log_we.delete(); log_wdata.delete();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        n = 0; cycles = -1; rdata = '0;
        while (cycles < 0 && n < 200) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (cpu_ready) begin cycles = n; rdata = cpu_rdata; end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        if (cycles < 0) begin
            n_cmp++; n_err++;
            $display("FAIL access_timeout: addr %h got no cpu_ready within %0d cycles", addr, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin n_err++;
            $display("FAIL reset_cpu: ready=%b rdata=%h want 0/0", cpu_ready, cpu_rdata); end
        n_cmp++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_err++;
            $display("FAIL reset_mem_ctl: req=%b we=%b want 0/0", mem_req, mem_we); end
        n_cmp++; if (mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin n_err++;
            $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
        n_cmp++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin n_err++;
            $display("FAIL reset_cnt: hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin n_err++;
            $display("FAIL reset_release: req=%b ready=%b want 0/0", mem_req, cpu_ready); end
    endtask

    task automatic test_cold_read;
        logic [31:0] rd; int cyc;
        access(1'b0, 30'h010, 32'h0, rd, cyc);
        n_cmp++; if (cyc !== 7) begin n_err++;
            $display("FAIL cold_latency: got %0d want 7", cyc); end
        n_cmp++; if (rd !== 32'hA5A50010) begin n_err++;
            $display("FAIL cold_rdata: got %h want a5a50010", rd); end
        n_cmp++; if (log_addr.size() !== 4) begin n_err++;
            $display("FAIL cold_beats: got %0d want 4", log_addr.size()); end
        if (log_addr.size() == 4)
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (log_addr[i] !== 30'h010 + 30'(i) || log_we[i] !== 1'b0) begin n_err++;
                    $display("FAIL cold_beat%0d: addr=%h we=%b want %h/0", i, log_addr[i],
                             log_we[i], 30'h010 + 30'(i)); end
            end
        n_cmp++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin n_err++;
            $display("FAIL cold_cnt: hit=%0d miss=%0d want 0/1", hit_cnt, miss_cnt); end
    endtask

    task automatic test_hit_read;
        logic [31:0] rd; int cyc;
        stray_ack = 1'b1;
        access(1'b0, 30'h011, 32'h0, rd, cyc);
        stray_ack = 1'b0;
        n_cmp++; if (cyc !== 2) begin n_err++;
            $display("FAIL hit_latency: got %0d want 2", cyc); end
        n_cmp++; if (rd !== 32'hA5A50011) begin n_err++;
            $display("FAIL hit_rdata: got %h want a5a50011", rd); end
        n_cmp++; if (log_addr.size() !== 0) begin n_err++;
            $display("FAIL hit_no_mem: got %0d beats want 0", log_addr.size()); end
        n_cmp++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin n_err++;
            $display("FAIL hit_cnt: hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt); end
    endtask

    task automatic test_writeback;
        logic [31:0] rd; int cyc;
        logic [31:0] wb_exp [4];
        logic [29:0] ea;
        wb_exp[0] = 32'hA5A50010; wb_exp[1] = 32'hA5A50011;
        wb_exp[2] = 32'hDEADBEEF; wb_exp[3] = 32'hA5A50013;
        access(1'b1, 30'h012, 32'hDEADBEEF, rd, cyc);
        n_cmp++; if (cyc !== 2 || hit_cnt !== 16'd2) begin n_err++;
            $display("FAIL wr_hit: cycles=%0d hit=%0d want 2/2", cyc, hit_cnt); end
        access(1'b0, 30'h112, 32'h0, rd, cyc);
        n_cmp++; if (cyc !== 11) begin n_err++;
            $display("FAIL dirty_latency: got %0d want 11", cyc); end
        n_cmp++; if (rd !== 32'hA5A50112) begin n_err++;
            $display("FAIL dirty_rdata: got %h want a5a50112", rd); end
        n_cmp++; if (log_addr.size() !== 8) begin n_err++;
            $display("FAIL dirty_beats: got %0d want 8", log_addr.size()); end
        if (log_addr.size() == 8)
            for (int i = 0; i < 8; i++) begin
                ea = (i < 4) ? 30'h010 + 30'(i) : 30'h110 + 30'(i - 4);
                n_cmp++;
                if (log_addr[i] !== ea || log_we[i] !== (i < 4)) begin n_err++;
                    $display("FAIL dirty_beat%0d: addr=%h we=%b want %h/%b", i, log_addr[i],
                             log_we[i], ea, (i < 4)); end
                if (i < 4) begin
                    n_cmp++;
                    if (log_wdata[i] !== wb_exp[i]) begin n_err++;
                        $display("FAIL wb_data%0d: got %h want %h", i, log_wdata[i], wb_exp[i]); end
                end
            end
        n_cmp++; if (miss_cnt !== 16'd2 || hit_cnt !== 16'd2) begin n_err++;
            $display("FAIL dirty_cnt: hit=%0d miss=%0d want 2/2", hit_cnt, miss_cnt); end
        access(1'b0, 30'h012, 32'h0, rd, cyc);
        n_cmp++; if (rd !== 32'hDEADBEEF || cyc !== 7) begin n_err++;
            $display("FAIL reload_written: rdata=%h cycles=%0d want deadbeef/7", rd, cyc); end
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; int cyc;
        wait_states = 3;
        stab_err = 0;
        access(1'b0, 30'h0A1, 32'h0, rd, cyc);
        wait_states = 0;
        n_cmp++; if (cyc !== 19) begin n_err++;
            $display("FAIL wait_latency: got %0d want 19", cyc); end
        n_cmp++; if (rd !== 32'hA5A500A1) begin n_err++;
            $display("FAIL wait_rdata: got %h want a5a500a1", rd); end
        n_cmp++; if (stab_err !== 0) begin n_err++;
            $display("FAIL wait_stable: got %0d changes want 0", stab_err); end
        n_cmp++; if (log_addr.size() !== 4) begin n_err++;
            $display("FAIL wait_beats: got %0d want 4", log_addr.size()); end
        else if (log_addr[0] !== 30'h0A0 || log_addr[3] !== 30'h0A3) begin
            n_cmp++; n_err++;
            $display("FAIL wait_addr: first=%h last=%h want 0a0/0a3", log_addr[0], log_addr[3]); end
        n_cmp++; if (miss_cnt !== 16'd4 || sat_miss_cnt !== 2'd3) begin n_err++;
            $display("FAIL miss_sat: miss=%0d sat=%0d want 4/3", miss_cnt, sat_miss_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; int cyc; int n;
        access(1'b0, 30'h0A2, 32'h0, rd, cyc);
        n_cmp++; if (cyc !== 2 || rd !== 32'hA5A500A2) begin n_err++;
            $display("FAIL b2b_first: cycles=%0d rdata=%h want 2/a5a500a2", cyc, rd); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h0A3;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!cpu_ready && n < 50);
        n_cmp++; if (n !== 3 || cpu_rdata !== 32'hA5A500A3) begin n_err++;
            $display("FAIL b2b_second: interval=%0d rdata=%h want 3/a5a500a3", n, cpu_rdata); end
        cpu_we = 1'b1; cpu_addr = 30'h0A0; cpu_wdata = 32'h12345678;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!cpu_ready && n < 50);
        cpu_req = 1'b0; cpu_we = 1'b0;
        n_cmp++; if (n !== 3) begin n_err++;
            $display("FAIL b2b_write: interval=%0d want 3", n); end
        access(1'b0, 30'h0A0, 32'h0, rd, cyc);
        n_cmp++; if (rd !== 32'h12345678 || hit_cnt !== 16'd6) begin n_err++;
            $display("FAIL b2b_readback: rdata=%h hit=%0d want 12345678/6", rd, hit_cnt); end
    endtask

    task automatic test_reset_mid_burst;
        logic [31:0] rd; int cyc; int n;
        wait_states = 2;
        log_addr.delete(); log_we.delete(); log_wdata.delete();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h230; cpu_wdata = '0;
        n = 0;
        while (log_addr.size() < 1 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk); #1;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 30'h231) begin n_err++;
            $display("FAIL rst_pre: req=%b addr=%h want 1/231", mem_req, mem_addr); end
        rst = 1'b1; cpu_req = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 30'h0) begin n_err++;
            $display("FAIL rst_mem_drop: req=%b addr=%h want 0/0", mem_req, mem_addr); end
        n_cmp++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || sat_miss_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL rst_cnt: hit=%0d miss=%0d sat_miss=%0d want 0/0/0",
                     hit_cnt, miss_cnt, sat_miss_cnt); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        wait_states = 0;
        access(1'b0, 30'h230, 32'h0, rd, cyc);
        n_cmp++; if (cyc !== 7 || log_addr.size() !== 4) begin n_err++;
            $display("FAIL rst_reread: cycles=%0d beats=%0d want 7/4", cyc, log_addr.size()); end
        n_cmp++; if (rd !== 32'hA5A50230 || miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rst_reread_data: rdata=%h miss=%0d hit=%0d want a5a50230/1/0",
                     rd, miss_cnt, hit_cnt); end
    endtask

    task automatic test_saturation;
        logic [31:0] rd; int cyc;
        access(1'b0, 30'h231, 32'h0, rd, cyc);
        access(1'b0, 30'h232, 32'h0, rd, cyc);
        access(1'b0, 30'h233, 32'h0, rd, cyc);
        n_cmp++; if (sat_hit_cnt !== 2'd3 || hit_cnt !== 16'd3) begin n_err++;
            $display("FAIL sat_reach: sat=%0d hit=%0d want 3/3", sat_hit_cnt, hit_cnt); end
        access(1'b0, 30'h230, 32'h0, rd, cyc);
        access(1'b0, 30'h231, 32'h0, rd, cyc);
        n_cmp++; if (sat_hit_cnt !== 2'd3 || hit_cnt !== 16'd5) begin n_err++;
            $display("FAIL sat_hold: sat=%0d hit=%0d want 3/5", sat_hit_cnt, hit_cnt); end
        n_cmp++; if (rd !== 32'hA5A50231 || sat_miss_cnt !== 2'd1) begin n_err++;
            $display("FAIL sat_misc: rdata=%h sat_miss=%0d want a5a50231/1", rd, sat_miss_cnt); end
        n_cmp++; if (sat_div !== 0) begin n_err++;
            $display("FAIL sat_lockstep: got %0d divergent cycles want 0", sat_div); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_read();
        test_hit_read();
        test_writeback();
        test_wait_states();
        test_back_to_back();
        test_reset_mid_burst();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
